// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC: one micro-rotation per clock, returning the
// K-scaled magnitude and atan2(y, x) in Q3.29 radians.
module cordic_vectoring_iter #(
  parameter int ITER = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [31:0] x_in,
  input  logic signed [31:0] y_in,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] mag,
  output logic signed [31:0] angle
);

  localparam logic signed [31:0] HALF_PI = 32'sh3243F6A9;
  localparam logic [4:0]         LAST    = 5'(ITER - 1);

  typedef enum logic {
    ST_IDLE,
    ST_ITER
  } state_t;

  state_t             state_q, state_d;
  logic signed [31:0] x_q, x_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] z_q, z_d;
  logic [4:0]         i_q, i_d;
  logic               done_q, done_d;
  logic signed [31:0] mag_q, mag_d;
  logic signed [31:0] angle_q, angle_d;

  logic signed [31:0] x_rot, y_rot, z_rot;
  logic signed [31:0] x_shift, y_shift, atan_i;

  // round(atan(2^-i) * 2^29); from i = 11 on the value is exactly 2^(29-i)
  function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
    logic signed [31:0] v;
    case (idx)
      5'd0:    v = 32'sh1921FB54;
      5'd1:    v = 32'sh0ED63383;
      5'd2:    v = 32'sh07D6DD7E;
      5'd3:    v = 32'sh03FAB753;
      5'd4:    v = 32'sh01FF55BB;
      5'd5:    v = 32'sh00FFEAAE;
      5'd6:    v = 32'sh007FFD55;
      5'd7:    v = 32'sh003FFFAB;
      5'd8:    v = 32'sh001FFFF5;
      5'd9:    v = 32'sh000FFFFF;
      5'd10:   v = 32'sh00080000;
      5'd11:   v = 32'sh00040000;
      5'd12:   v = 32'sh00020000;
      5'd13:   v = 32'sh00010000;
      5'd14:   v = 32'sh00008000;
      5'd15:   v = 32'sh00004000;
      5'd16:   v = 32'sh00002000;
      5'd17:   v = 32'sh00001000;
      5'd18:   v = 32'sh00000800;
      5'd19:   v = 32'sh00000400;
      5'd20:   v = 32'sh00000200;
      5'd21:   v = 32'sh00000100;
      5'd22:   v = 32'sh00000080;
      5'd23:   v = 32'sh00000040;
      5'd24:   v = 32'sh00000020;
      5'd25:   v = 32'sh00000010;
      5'd26:   v = 32'sh00000008;
      5'd27:   v = 32'sh00000004;
      default: v = 32'sh00000000;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      done_q  <= 1'b0;
      mag_q   <= '0;
      angle_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      done_q  <= done_d;
      mag_q   <= mag_d;
      angle_q <= angle_d;
    end
  end

  always_comb begin
    x_shift = x_q >>> i_q;
    y_shift = y_q >>> i_q;
    atan_i  = atan_lut(i_q);
    // rotate toward y = 0; direction chosen by the sign of the current y
    if (y_q[31]) begin
      x_rot = x_q - y_shift;
      y_rot = y_q + x_shift;
      z_rot = z_q - atan_i;
    end else begin
      x_rot = x_q + y_shift;
      y_rot = y_q - x_shift;
      z_rot = z_q + atan_i;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    done_d  = 1'b0;
    mag_d   = mag_q;
    angle_d = angle_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // left half-plane inputs are pre-rotated by +/-pi/2 into x >= 0
          if (!x_in[31]) begin
            x_d = x_in;
            y_d = y_in;
            z_d = '0;
          end else if (!y_in[31]) begin
            x_d = y_in;
            y_d = -x_in;
            z_d = HALF_PI;
          end else begin
            x_d = -y_in;
            y_d = x_in;
            z_d = -HALF_PI;
          end
          i_d     = '0;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        i_d = i_q + 5'd1;
        if (i_q == LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          mag_d   = x_rot;
          angle_d = z_rot;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy  = (state_q == ST_ITER);
  assign done  = done_q;
  assign mag   = mag_q;
  assign angle = angle_q;

endmodule
